// File: rtl/instr_fetch.sv
// Instruction fetch FSM: FETCH -> HOLD -> EXEC, with PC redirect on execute-stage branch resolution.
// Optional fetch timeout with sticky fetch_err and HALT, enabled by `define FETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus1,
  input  logic        res_valid,
  input  logic [1:0]  res_instr_select,
  input  logic [5:0]  res_opcode,
  input  logic [31:0] res_rs_data,
  input  logic        flag_carry,
  output logic        fetch_err
);

  localparam logic [5:0] OP_BR   = 6'd16;
  localparam logic [5:0] OP_B    = 6'd17;
  localparam logic [5:0] OP_BL   = 6'd18;
  localparam logic [5:0] OP_BLTZ = 6'd19;
  localparam logic [5:0] OP_BZ   = 6'd20;
  localparam logic [5:0] OP_BNZ  = 6'd21;
  localparam logic [5:0] OP_BCY  = 6'd22;
  localparam logic [5:0] OP_BNCY = 6'd23;

  typedef enum logic [1:0] {FETCH, HOLD, EXEC, HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        w_taken;
  logic [31:0] w_pc_plus1;
  logic [31:0] w_rel_target;
  logic [31:0] w_next_pc;

  assign w_pc_plus1   = r_pc + 32'd1;
  assign w_rel_target = w_pc_plus1 + {{16{r_instr[15]}}, r_instr[15:0]};

  always_comb begin
    w_taken = 1'b0;
    case (res_opcode)
      OP_BR, OP_B, OP_BL: w_taken = 1'b1;
      OP_BLTZ:            w_taken = res_rs_data[31];
      OP_BZ:              w_taken = (res_rs_data == 32'd0);
      OP_BNZ:             w_taken = (res_rs_data != 32'd0);
      OP_BCY:             w_taken = flag_carry;
      OP_BNCY:            w_taken = !flag_carry;
      default:            w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next_pc = w_pc_plus1;
    if (w_taken) begin
      case (res_instr_select)
        2'b01:   w_next_pc = w_rel_target;
        2'b10:   w_next_pc = {6'b0, r_instr[25:0]};
        2'b11:   w_next_pc = res_rs_data;
        default: w_next_pc = w_pc_plus1;
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_instr <= 32'd0;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= HOLD;
          end else if (r_cnt == 8'(TIMEOUT_CYC - 1)) begin
            // The cycle that brings the wait count to TIMEOUT_CYC gives up for good.
            r_err   <= 1'b1;
            r_state <= HALT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        HOLD: if (instr_ready) r_state <= EXEC;
        EXEC: begin
          if (res_valid) begin
            r_pc    <= w_next_pc;
            r_cnt   <= 8'd0;
            r_state <= FETCH;
          end
        end
        default: r_state <= HALT;
      endcase
    end
  end

  assign fetch_err = r_err;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_instr <= 32'd0;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= HOLD;
          end
        end
        HOLD: if (instr_ready) r_state <= EXEC;
        EXEC: begin
          if (res_valid) begin
            r_pc    <= w_next_pc;
            r_state <= FETCH;
          end
        end
        default: r_state <= HALT;
      endcase
    end
  end

  assign fetch_err = 1'b0;
`endif

  // Gating with rst keeps the handshakes quiet during reset, whatever state is held.
  assign imem_req    = (r_state == FETCH) && !rst;
  assign instr_valid = (r_state == HOLD) && !rst;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign pc_out      = r_pc;
  assign pc_plus1    = w_pc_plus1;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: queued expected fetch addresses checked as each request appears.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_BR   = 6'd16;
  localparam logic [5:0] OP_B    = 6'd17;
  localparam logic [5:0] OP_BL   = 6'd18;
  localparam logic [5:0] OP_BLTZ = 6'd19;
  localparam logic [5:0] OP_BZ   = 6'd20;
  localparam logic [5:0] OP_BNZ  = 6'd21;
  localparam logic [5:0] OP_BCY  = 6'd22;
  localparam logic [5:0] OP_BNCY = 6'd23;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_plus1;
  logic        res_valid;
  logic [1:0]  res_instr_select;
  logic [5:0]  res_opcode;
  logic [31:0] res_rs_data;
  logic        flag_carry;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_out(pc_out), .pc_plus1(pc_plus1),
    .res_valid(res_valid), .res_instr_select(res_instr_select),
    .res_opcode(res_opcode), .res_rs_data(res_rs_data),
    .flag_carry(flag_carry), .fetch_err(fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for the next request and compares its address with the head of the queue.
  task automatic wait_req(output logic [31:0] addr);
    int n = 0;
    while (!imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("req_wait", {31'd0, imem_req}, 32'd1);
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
      addr = 32'hx;
    end else begin
      addr = exp_q.pop_front();
    end
    check("fetch_addr", imem_addr, addr);
  endtask

  // One full instruction: fetch with ack delay, optional HOLD stall, EXEC, resolution.
  task automatic run_instr(input logic [31:0] rdata, input int ack_dly, input int stall,
                           input logic [1:0] sel, input logic [5:0] opc,
                           input logic [31:0] rs, input logic cy, input logic [31:0] exp_next);
    logic [31:0] addr;
    wait_req(addr);
    repeat (ack_dly) begin
      @(negedge clk);
      check("req_held", {31'd0, imem_req}, 32'd1);
    end
    imem_ack = 1'b1;
    imem_rdata = rdata;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_instr", instr, rdata);
    check("hold_pc", pc_out, addr);
    check("hold_pc_plus1", pc_plus1, addr + 32'd1);
    for (int i = 0; i < stall; i++) begin
      res_valid = (i == 2);
      imem_ack  = (i == 3);
      @(negedge clk);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_instr", instr, rdata);
      check("stall_noreq", {31'd0, imem_req}, 32'd0);
      check("stall_pc", pc_out, addr);
    end
    res_valid = 1'b0;
    imem_ack = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check("exec_novalid", {31'd0, instr_valid}, 32'd0);
    check("exec_noreq", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("exec_ack_ignored", instr, rdata);
    res_valid = 1'b1;
    res_instr_select = sel;
    res_opcode = opc;
    res_rs_data = rs;
    flag_carry = cy;
    exp_q.push_back(exp_next);
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int n;
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    instr_ready = 1'b0;
    res_valid = 1'b0;
    res_instr_select = 2'b00;
    res_opcode = OP_ADD;
    res_rs_data = 32'd0;
    flag_carry = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    check("rst_pc", pc_out, RESET_PC);
    check("rst_instr", instr, 32'd0);
    exp_q.push_back(RESET_PC);
    rst = 1'b0;
    #1 check("req_after_rst", {31'd0, imem_req}, 32'd1);

    run_instr(32'h0000_1234, 2, 0, 2'b11, OP_BR,   32'd5,         1'b0, 32'd5);
    run_instr(32'h0000_0000, 0, 0, 2'b00, OP_ADD,  32'd0,         1'b0, 32'd6);
    run_instr(32'h0000_0000, 1, 0, 2'b11, OP_BR,   32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF);
    run_instr(32'h0000_0000, 0, 0, 2'b00, OP_ADD,  32'd0,         1'b0, 32'd0);
    run_instr(32'h0000_0000, 0, 0, 2'b11, OP_BR,   32'd10,        1'b0, 32'd10);
    run_instr(32'h0000_FFFC, 0, 0, 2'b01, OP_BZ,   32'd0,         1'b0, 32'd7);
    run_instr(32'h0000_0000, 0, 0, 2'b11, OP_BR,   32'd10,        1'b0, 32'd10);
    run_instr(32'h0000_FFFC, 0, 0, 2'b01, OP_BZ,   32'd1,         1'b0, 32'd11);
    run_instr(32'h4800_0100, 0, 0, 2'b10, OP_BL,   32'd0,         1'b0, 32'h100);
    run_instr(32'h0000_0000, 3, 5, 2'b11, OP_BR,   32'h40,        1'b0, 32'h40);
    run_instr(32'h0000_0010, 0, 0, 2'b01, OP_BCY,  32'd0,         1'b0, 32'h41);
    run_instr(32'h0000_0002, 0, 0, 2'b01, OP_BLTZ, 32'h8000_0000, 1'b0, 32'h44);
    run_instr(32'h0000_0002, 0, 0, 2'b01, OP_BNCY, 32'd0,         1'b0, 32'h47);
    run_instr(32'h0000_0000, 0, 0, 2'b01, OP_BNZ,  32'd0,         1'b0, 32'h48);
    run_instr(32'h0000_0000, 0, 0, 2'b11, OP_ADD,  32'h1234,      1'b0, 32'h49);
    run_instr(32'h0300_0020, 0, 0, 2'b10, OP_B,    32'd0,         1'b0, 32'h0300_0020);

    // Reset during HOLD abandons the instruction and restarts at RESET_PC.
    wait_req(a);
    imem_ack = 1'b1;
    imem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    imem_ack = 1'b0;
    check("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
    rst = 1'b1;
    #1 check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_pc", pc_out, RESET_PC);
    check("midrst_instr", instr, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    run_instr(32'h0000_0000, 0, 0, 2'b11, OP_BR, 32'h77, 1'b0, 32'h77);

    // Fetch that never receives an ack.
    wait_req(a);
    n = 0;
    while (n < 300 && !fetch_err) begin
      @(negedge clk);
      n++;
    end
`ifdef FETCH_TIMEOUT_EN
    check("timeout_cycles", n, 32'd255);
    check("timeout_err", {31'd0, fetch_err}, 32'd1);
    repeat (5) @(negedge clk);
    check("halt_req", {31'd0, imem_req}, 32'd0);
    check("halt_err", {31'd0, fetch_err}, 32'd1);
    check("halt_valid", {31'd0, instr_valid}, 32'd0);
`else
    check("notimeout_err", {31'd0, fetch_err}, 32'd0);
    check("notimeout_req", {31'd0, imem_req}, 32'd1);
    check("notimeout_addr", imem_addr, 32'h77);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, the maximum number of cycles to wait for imem_ack (used only with FETCH_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports imem_req (output, 1 bit) and imem_addr (output, 32 bits): instruction-memory read request and word address.
REQ-006 SHALL have ports imem_ack (input, 1 bit) and imem_rdata (input, 32 bits): read completion and the returned instruction word.
REQ-007 SHALL have ports instr (output, 32 bits), instr_valid (output, 1 bit) and instr_ready (input, 1 bit): instruction handoff to the decode/control stage.
REQ-008 SHALL have ports pc_out (output, 32 bits) and pc_plus1 (output, 32 bits): PC of the held instruction and that PC plus 1, the latter being the link value for bl.
REQ-009 SHALL have ports res_valid (input, 1 bit), res_instr_select (input, 2 bits), res_opcode (input, 6 bits), res_rs_data (input, 32 bits) and flag_carry (input, 1 bit): execute-stage branch resolution inputs.
REQ-010 SHALL have port fetch_err, output, 1 bit: sticky fetch timeout indication.

Function
REQ-011 SHALL implement the FSM states FETCH, HOLD, EXEC and HALT.
REQ-012 FETCH: imem_req=1 and imem_addr=pc; on imem_ack, capture imem_rdata into instr and move to HOLD. A same-cycle ack is legal.
REQ-013 HOLD: instr_valid=1 and instr stays stable; when instr_valid && instr_ready, move to EXEC.
REQ-014 EXEC: wait for res_valid; on res_valid, load pc with next_pc and move to FETCH. imem_req=0 and instr_valid=0 while in EXEC.
REQ-015 next_pc SHALL be selected by res_instr_select as follows:
- 00: pc+1.
- 01: taken ? pc+1+sext(instr[15:0]) : pc+1.
- 10: taken ? {6'b0, instr[25:0]} : pc+1.
- 11: taken ? res_rs_data : pc+1.
REQ-016 taken SHALL be decided by res_opcode:
- br, b, bl: 1.
- bltz: res_rs_data[31].
- bz: res_rs_data==0.
- bnz: res_rs_data!=0.
- bcy: flag_carry.
- bncy: !flag_carry.
- Any other opcode: 0.
REQ-017 All PC arithmetic SHALL be 32-bit modulo 2^32; pc=32'hFFFF_FFFF with select 00 SHALL give next_pc=0.
REQ-018 pc_out SHALL equal pc, and pc_plus1 SHALL equal pc+1, in all states.
REQ-019 imem_ack outside FETCH and res_valid outside EXEC SHALL be ignored.
REQ-020 Minimum loop time for one instruction SHALL be 3 cycles: ack in FETCH, ready in HOLD, res_valid in EXEC.
REQ-021 HALT: imem_req=0, instr_valid=0, and the state holds until rst.

Reset
REQ-022 On rst=1 at a clock edge, the block SHALL set pc=RESET_PC, state=FETCH, instr=0, fetch_err=0 and the timeout counter to 0.
REQ-023 While rst=1, imem_req and instr_valid SHALL be 0; imem_req rises in the first cycle after rst deasserts.
REQ-024 Reset asserted mid-fetch, mid-HOLD or mid-EXEC SHALL abandon the transaction; an ack arriving after reset SHALL be ignored unless a new request is outstanding.

Configuration
REQ-025 The macro FETCH_TIMEOUT_EN SHALL control the fetch timeout feature.
REQ-026 With FETCH_TIMEOUT_EN defined, an 8-bit counter SHALL:
- clear on entry to FETCH;
- increment each FETCH cycle without imem_ack;
- on reaching TIMEOUT_CYC, set fetch_err=1 (sticky) and move the FSM to HALT.
REQ-027 Without FETCH_TIMEOUT_EN, FETCH SHALL wait indefinitely, fetch_err SHALL be constant 0, and HALT SHALL be unreachable.

Verification
REQ-028 Reset scenario: release rst with RESET_PC=0 and ack after 2 cycles with rdata=32'h0000_1234 -> imem_addr=0, instr=32'h0000_1234, instr_valid=1 on the following cycle.
REQ-029 Sequential scenario: add (select 00) at pc=5 -> next imem_addr=6; with pc=32'hFFFF_FFFF -> next imem_addr=0.
REQ-030 Conditional branch scenario: bz at pc=10 with instr[15:0]=16'hFFFC and rs_data=0 -> next address 7; with rs_data=1 -> next address 11.
REQ-031 Label and register branch scenario:
- bl with label 26'h100 -> next address 32'h100 and pc_plus1 presented before redirect.
- br with rs_data=32'h40 -> next address 32'h40.
- bcy with carry=0 -> pc+1.
REQ-032 Backpressure scenario: hold instr_ready=0 for 5 cycles -> instr stable, instr_valid=1, no imem_req; a res_valid pulse during HOLD is ignored.
REQ-033 Timeout scenario with FETCH_TIMEOUT_EN: no ack for 255 cycles -> fetch_err=1 and imem_req=0 thereafter; with the macro undefined -> fetch_err stays 0 and req is held.
